// File: rtl/uart_pkg.sv
// Shared UART package: transmitter/receiver state encodings and legal parameter ranges.
package uart_pkg;

  // Legal ranges for the frame-format parameters.
  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;
  localparam int unsigned STOP_BITS_MIN = 1;
  localparam int unsigned STOP_BITS_MAX = 2;

  // Receiver control states.
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Transmitter control states; TX_PARITY is only reachable in the parity build.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Source select for the registered serial line.
  typedef enum logic [1:0] {
    TX_SEL_MARK   = 2'd0,
    TX_SEL_SPACE  = 2'd1,
    TX_SEL_DATA   = 2'd2,
    TX_SEL_PARITY = 2'd3
  } tx_sel_e;

endpackage

// File: rtl/uart_tx_controller.sv
// UART transmit control FSM. Drives the counter/shift-register strobes and
// selects the next serial-line level from the upcoming state.
// Optional parity state enabled by defining UART_TX_PARITY_EN.
module uart_tx_controller
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid_i,
  input  logic       clk_count_eq_last_i,
  input  logic       clk_count_eq_penult_i,
  input  logic       bit_count_eq_last_i,
  input  logic       stop_count_eq_last_i,
  output logic       load_en_o,
  output logic       shift_en_o,
  output logic       clk_clear_o,
  output logic       bit_clear_o,
  output logic       bit_increment_o,
  output logic [1:0] tx_sel_o,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       tx_done_o
);

  tx_state_e state_q, state_d;
  logic      busy_q, busy_d;
  logic      tx_done_q, tx_done_d;
  tx_sel_e   tx_sel_d;

  // State and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= TX_IDLE;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d         = state_q;
    load_en_o       = 1'b0;
    shift_en_o      = 1'b0;
    clk_clear_o     = 1'b0;
    bit_clear_o     = 1'b0;
    bit_increment_o = 1'b0;
    tx_done_d       = 1'b0;
    case (state_q)
      TX_IDLE: begin
        clk_clear_o = 1'b1;
        if (tx_valid_i) begin
          load_en_o   = 1'b1;
          bit_clear_o = 1'b1;
          state_d     = TX_START;
        end
      end
      TX_START: begin
        if (clk_count_eq_last_i) begin
          bit_clear_o = 1'b1;
          state_d     = TX_DATA;
        end
      end
      TX_DATA: begin
        if (clk_count_eq_last_i) begin
          shift_en_o = 1'b1;
          if (bit_count_eq_last_i) begin
            // Bit counter is reused to count stop bits.
            bit_clear_o = 1'b1;
`ifdef UART_TX_PARITY_EN
            state_d     = TX_PARITY;
`else
            state_d     = TX_STOP;
`endif
          end else begin
            bit_increment_o = 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (clk_count_eq_last_i) begin
          state_d = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        // Registered pulse lands on the final cycle of the last stop bit.
        if (stop_count_eq_last_i && clk_count_eq_penult_i) begin
          tx_done_d = 1'b1;
        end
        if (clk_count_eq_last_i) begin
          if (stop_count_eq_last_i) begin
            state_d = TX_IDLE;
          end else begin
            bit_increment_o = 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase

    busy_d = (state_d != TX_IDLE);

    // Line level is chosen from the state being entered so tx stays flop-driven.
    case (state_d)
      TX_START: tx_sel_d = TX_SEL_SPACE;
      TX_DATA:  tx_sel_d = TX_SEL_DATA;
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_sel_d = TX_SEL_PARITY;
`endif
      default:  tx_sel_d = TX_SEL_MARK;
    endcase
  end

  assign tx_sel_o   = tx_sel_d;
  assign tx_ready_o = (state_q == TX_IDLE);
  assign busy_o     = busy_q;
  assign tx_done_o  = tx_done_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data LSB-first, optional even parity,
// STOP_BITS stop bits, each held CLKS_PER_BIT cycles.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CLK_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CLK_PENULT = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);

  logic [CNT_W-1:0]     clk_count_q, clk_count_d;
  logic [BIT_W-1:0]     bit_count_q, bit_count_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic       load_en, shift_en, clk_clear, bit_clear, bit_increment;
  logic [1:0] tx_sel;
  logic       clk_count_eq_last, clk_count_eq_penult;
  logic       bit_count_eq_last, stop_count_eq_last;

  assign clk_count_eq_last   = (clk_count_q == CLK_LAST);
  assign clk_count_eq_penult = (clk_count_q == CLK_PENULT);
  assign bit_count_eq_last   = (bit_count_q == BIT_LAST);
  assign stop_count_eq_last  = (bit_count_q == STOP_LAST);

  uart_tx_controller u_ctrl (
    .clk                   (clk),
    .reset_n               (reset_n),
    .tx_valid_i            (tx_valid),
    .clk_count_eq_last_i   (clk_count_eq_last),
    .clk_count_eq_penult_i (clk_count_eq_penult),
    .bit_count_eq_last_i   (bit_count_eq_last),
    .stop_count_eq_last_i  (stop_count_eq_last),
    .load_en_o             (load_en),
    .shift_en_o            (shift_en),
    .clk_clear_o           (clk_clear),
    .bit_clear_o           (bit_clear),
    .bit_increment_o       (bit_increment),
    .tx_sel_o              (tx_sel),
    .tx_ready_o            (tx_ready),
    .busy_o                (busy),
    .tx_done_o             (tx_done)
  );

  // Counters, shift register and next serial-line level.
  always_comb begin
    clk_count_d = clk_count_q + CNT_W'(1);
    bit_count_d = bit_count_q;
    shift_d     = shift_q;

    if (clk_clear || clk_count_eq_last) begin
      clk_count_d = '0;
    end

    if (bit_clear) begin
      bit_count_d = '0;
    end else if (bit_increment) begin
      bit_count_d = bit_count_q + BIT_W'(1);
    end

    if (load_en) begin
      shift_d = tx_data;
    end else if (shift_en) begin
      shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
    end

`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
    if (load_en) begin
      parity_d = ^tx_data;
    end
`endif

    case (tx_sel_e'(tx_sel))
      TX_SEL_SPACE:  tx_d = 1'b0;
      TX_SEL_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      TX_SEL_PARITY: tx_d = parity_q;
`endif
      default:       tx_d = 1'b1;
    endcase
  end

  // Datapath registers; tx idles high and returns high on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_count_q <= '0;
      bit_count_q <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
    end else begin
      clk_count_q <= clk_count_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the accepted word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, DATA_BITS=8; a second
// instance uses STOP_BITS=2. Follows UART_TX_PARITY_EN when defined.
module tb_uart_tx;

  localparam int CPB = 4;

  // Hand-built frames, bit i = line level of bit slot i: {stop(s), [parity], data, start}.
`ifdef UART_TX_PARITY_EN
  localparam int          NS1   = 11;
  localparam int          NS2   = 12;
  localparam logic [11:0] FR_A5 = 12'({1'b1, 1'b0, 8'hA5, 1'b0});
  localparam logic [11:0] FR_00 = 12'({1'b1, 1'b0, 8'h00, 1'b0});
  localparam logic [11:0] FR_FF = 12'({1'b1, 1'b0, 8'hFF, 1'b0});
  localparam logic [11:0] FR_07 = 12'({1'b1, 1'b1, 8'h07, 1'b0});
  localparam logic [11:0] FR_55 = 12'({1'b1, 1'b0, 8'h55, 1'b0});
  localparam logic [11:0] FR_81 = 12'({2'b11, 1'b0, 8'h81, 1'b0});
`else
  localparam int          NS1   = 10;
  localparam int          NS2   = 11;
  localparam logic [11:0] FR_A5 = 12'({1'b1, 8'hA5, 1'b0});
  localparam logic [11:0] FR_00 = 12'({1'b1, 8'h00, 1'b0});
  localparam logic [11:0] FR_FF = 12'({1'b1, 8'hFF, 1'b0});
  localparam logic [11:0] FR_07 = 12'({1'b1, 8'h07, 1'b0});
  localparam logic [11:0] FR_55 = 12'({1'b1, 8'h55, 1'b0});
  localparam logic [11:0] FR_81 = 12'({2'b11, 8'h81, 1'b0});
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       valid1, valid2;
  logic [7:0] data1, data2;
  logic       ready1, tx1, busy1, done1;
  logic       ready2, tx2, busy2, done2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_valid (valid1),
    .tx_data  (data1),
    .tx_ready (ready1),
    .tx       (tx1),
    .busy     (busy1),
    .tx_done  (done1)
  );

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_valid (valid2),
    .tx_data  (data2),
    .tx_ready (ready2),
    .tx       (tx2),
    .busy     (busy2),
    .tx_done  (done2)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      valid2 = v;
      data2  = d;
    end else begin
      valid1 = v;
      data1  = d;
    end
  endtask

  task automatic check_idle(input string tag, input bit sel);
    check({tag, " ready"}, sel ? ready2 : ready1, 1'b1);
    check({tag, " busy"},  sel ? busy2  : busy1,  1'b0);
    check({tag, " tx"},    sel ? tx2    : tx1,    1'b1);
    check({tag, " done"},  sel ? done2  : done1,  1'b0);
  endtask

  // Called at cycle 0 (just after an edge); returns at cycle nslots*CPB+1.
  task automatic send_frame(input string tag, input bit sel, input logic [7:0] data,
                            input logic [11:0] slots, input int nslots,
                            input bit keep_valid, input logic [7:0] next_data,
                            input int pulse_cycle);
    int last;
    last = nslots * CPB;
    check({tag, " ready c0"}, sel ? ready2 : ready1, 1'b1);
    drive(sel, 1'b1, data);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        if (keep_valid) drive(sel, 1'b1, next_data);
        else            drive(sel, 1'b0, ~data);
      end
      if (pulse_cycle != 0 && c == pulse_cycle)     drive(sel, 1'b1, 8'h3C);
      if (pulse_cycle != 0 && c == pulse_cycle + 1) drive(sel, 1'b0, 8'h00);
      check($sformatf("%s tx c%0d", tag, c),    sel ? tx2 : tx1, slots[4'((c - 1) / CPB)]);
      check($sformatf("%s done c%0d", tag, c),  sel ? done2 : done1, (c == last));
      check($sformatf("%s busy c%0d", tag, c),  sel ? busy2 : busy1, 1'b1);
      check($sformatf("%s ready c%0d", tag, c), sel ? ready2 : ready1, 1'b0);
    end
    @(posedge clk);
    #1;
    check_idle($sformatf("%s end c%0d", tag, last + 1), sel);
  endtask

  initial begin
    reset_n = 1'b0;
    valid1  = 1'b0;
    valid2  = 1'b0;
    data1   = 8'h00;
    data2   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset dut1", 1'b0);
    check_idle("reset dut2", 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame.
    send_frame("a5", 1'b0, 8'hA5, FR_A5, NS1, 1'b0, 8'h00, 0);

    // Back-to-back with tx_valid held high: 00 then FF.
    send_frame("b2b_00", 1'b0, 8'h00, FR_00, NS1, 1'b1, 8'hFF, 0);
    send_frame("b2b_ff", 1'b0, 8'hFF, FR_FF, NS1, 1'b0, 8'h00, 0);

    // A 3C pulse at cycle 10 is ignored while busy.
    send_frame("ign_07", 1'b0, 8'h07, FR_07, NS1, 1'b0, 8'h00, 10);

    // Reset during data bit 3 (cycles 17..20).
    drive(1'b0, 1'b1, 8'hA5);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h00);
    for (int c = 2; c <= 18; c++) begin
      @(posedge clk);
      #1;
    end
    check("pre-reset tx d3", tx1, 1'b0);
    check("pre-reset busy", busy1, 1'b1);
    reset_n = 1'b0;
    #1;
    check_idle("midframe reset", 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame("post_55", 1'b0, 8'h55, FR_55, NS1, 1'b0, 8'h00, 0);

    // Two stop bits.
    send_frame("stop2_81", 1'b1, 8'h81, FR_81, NS2, 1'b0, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, the sending end of the team's UART link.
- Accepts a parallel byte via a valid/ready handshake and serializes it as: start bit (0), data LSB-first, optional parity, stop bit(s) (1).
- Each bit is held for CLKS_PER_BIT clock cycles, matching the receiver's bit timing.
- Structured as a control FSM driving a clock counter, a bit counter and a shift register.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- tx_valid  input  1  tx_data holds a word to send.
- tx_data  input  DATA_BITS  parallel word to transmit.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- tx  output  1  serial line, registered; idles high.
- busy  output  1  frame in progress (state != IDLE).
- tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; tx=1, tx_ready=1, busy=0, tx_done=0.
  - Counters and shift register cleared.
  - A reset mid-frame abandons the frame immediately; tx returns high asynchronously.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
  - IDLE: when tx_valid && tx_ready, capture tx_data into the shift register, clear clk_count and bit_count, go to START. tx=1 throughout.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift register bit 0. At the end of each bit period, shift right and increment bit_count. After DATA_BITS bits, go to PARITY if enabled, else STOP.
  - PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 on the final cycle, then go to IDLE.
- Bit timing:
  - clk_count runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Width of clk_count is $clog2(CLKS_PER_BIT).
  - Width of bit_count is $clog2(DATA_BITS+1).
- Latency:
  - The tx falling edge (start bit) appears the cycle after the accepting handshake.
  - Frame length, acceptance to tx_done inclusive, is (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- Handshake:
  - tx_ready is a combinational decode of state==IDLE.
  - tx_valid while busy is ignored; no queuing.
  - tx_data is sampled only on the accepting cycle; later changes have no effect on the frame in flight.
- Back-to-back frames:
  - After tx_done the block spends exactly one IDLE cycle (tx=1, tx_ready=1).
  - If tx_valid is high in that cycle, it is accepted and the start bit follows on the next cycle.
  - The minimum inter-frame stop time is therefore STOP_BITS*CLKS_PER_BIT+1 cycles.
- Outputs are glitch-free; tx is driven from a flop.

Optional Feature:
- Macro UART_TX_PARITY_EN.
  - Defined: the PARITY state is inserted after DATA. The bit sent is even parity, the XOR of the captured data word, computed at acceptance and stored in a flop.
  - Undefined: the PARITY state, parity flop and related logic are absent; DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP).
  - Legal-range constants for DATA_BITS and STOP_BITS.
  - Reuses its existing receiver state typedefs.
- Sub-module uart_tx_controller: the FSM only.
  - Inputs: clk_count_eq_last, bit_count_eq_last, tx_valid.
  - Outputs: shift_en, load_en, clk_clear, bit_increment, tx_sel, tx_done.
- uart_tx instantiates it alongside the counters and shift register, mirroring the receiver's controller/datapath split.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated):
- Basic frame, tx_data=8'hA5 accepted at cycle 0:
  - tx over cycles 1..40, each level held 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - tx_done high at cycle 40 only; tx_ready high again at cycle 41.
- Back-to-back, tx_valid held high with 8'h00 then 8'hFF:
  - Second accept at cycle 41.
  - Second start bit at cycles 42..45; second tx_done at cycle 81.
- Busy ignore: pulse tx_valid with 8'h3C at cycle 10 of a frame -> no effect; the frame and tx_done timing are unchanged.
- Reset mid-frame: drive reset_n=0 during DATA bit 3 -> tx=1, busy=0, tx_ready=1 immediately. A new frame (8'h55) after release is correct.
- Parity (UART_TX_PARITY_EN defined):
  - 8'hA5 -> parity bit 0 on cycles 37..40; tx_done at cycle 44.
  - 8'h07 -> parity bit 1.
- STOP_BITS=2, 8'h81 -> stop high for 8 cycles; tx_done at cycle 44.
